// File: rtl/sonar_scheduler.sv
// Round-robin ultrasonic ping scheduler: triggers one sensor at a time, times its echo
// in microseconds, converts the width to centimetres and hands results over valid/ready.
module sonar_scheduler #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int N_SENSORS    = 4,
  parameter int TRIG_US      = 10,
  parameter int ECHO_WAIT_US = 30_000,
  parameter int ECHO_MAX_US  = 25_000,
  parameter int HOLDOFF_US   = 60_000,
  parameter int CM_W         = 9,
  localparam int ID_W        = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [ID_W-1:0]      result_id,
  output logic [CM_W-1:0]      result_cm,
  output logic                 result_timeout,
  output logic                 busy
);

  localparam int TICK_DIV = CLK_FREQ / 1_000_000;
  localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int US_A     = (TRIG_US > HOLDOFF_US) ? TRIG_US : HOLDOFF_US;
  localparam int US_B     = (ECHO_WAIT_US > ECHO_MAX_US) ? ECHO_WAIT_US : ECHO_MAX_US;
  localparam int US_MAX   = (US_A > US_B) ? US_A : US_B;
  localparam int US_W     = $clog2(US_MAX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, RESULT, HOLDOFF} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     id, last, pick, cand;
  logic                pick_ok;
  logic [N_SENSORS-1:0] echo_meta, echo_sync, echo_sync_d;
  logic [PS_W-1:0]     presc;
  logic [US_W-1:0]     us_cnt;
  logic [5:0]          sub_cnt, sub_nxt;
  logic [CM_W-1:0]     cm_cnt, cm_nxt;
  logic                tick, rise, fall;

  function automatic logic [CM_W-1:0] cm_sat_inc(input logic [CM_W-1:0] cm);
    return (cm == {CM_W{1'b1}}) ? cm : cm + 1'b1;
  endfunction

  assign tick = (presc == PS_W'(TICK_DIV - 1));
  assign rise = echo_sync[id] & ~echo_sync_d[id];
  assign fall = ~echo_sync[id] & echo_sync_d[id];

  // Next enabled sensor after the last one served, searched circularly.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N_SENSORS; k++) begin
      cand = ID_W'((int'(last) + k) % N_SENSORS);
      if (!pick_ok && sensor_mask[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // 58 us of echo per centimetre; the tick of the current cycle is included so a
  // falling edge on a tick boundary still counts that final microsecond.
  always_comb begin
    sub_nxt = sub_cnt;
    cm_nxt  = cm_cnt;
    if (tick) begin
      if (sub_cnt == 6'd57) begin
        sub_nxt = '0;
        cm_nxt  = cm_sat_inc(cm_cnt);
      end else begin
        sub_nxt = sub_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && pick_ok) state_nxt = TRIG;
      TRIG:      if (tick && us_cnt == US_W'(TRIG_US - 1)) state_nxt = WAIT_RISE;
      WAIT_RISE: if (rise) state_nxt = MEASURE;
                 else if (tick && us_cnt == US_W'(ECHO_WAIT_US - 1)) state_nxt = RESULT;
      MEASURE:   if (fall || (tick && us_cnt == US_W'(ECHO_MAX_US - 1))) state_nxt = RESULT;
      RESULT:    if (result_ready) state_nxt = HOLDOFF;
      HOLDOFF:   if (tick && us_cnt == US_W'(HOLDOFF_US - 1)) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      id             <= '0;
      last           <= ID_W'(N_SENSORS - 1);
      echo_meta      <= '0;
      echo_sync      <= '0;
      echo_sync_d    <= '0;
      presc          <= '0;
      us_cnt         <= '0;
      sub_cnt        <= '0;
      cm_cnt         <= '0;
      result_cm      <= '0;
      result_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      echo_meta   <= echo;
      echo_sync   <= echo_meta;
      echo_sync_d <= echo_sync;
      // Prescaler restarts on every state entry so durations are whole microseconds.
      if (state_nxt != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else if (tick) begin
        presc  <= '0;
        us_cnt <= us_cnt + 1'b1;
      end else begin
        presc  <= presc + 1'b1;
      end
      case (state)
        IDLE: if (state_nxt == TRIG) id <= pick;
        WAIT_RISE: begin
          sub_cnt <= '0;
          cm_cnt  <= '0;
          if (state_nxt == RESULT) begin
            result_cm      <= '1;
            result_timeout <= 1'b1;
          end
        end
        MEASURE: begin
          sub_cnt <= sub_nxt;
          cm_cnt  <= cm_nxt;
          if (state_nxt == RESULT) begin
            result_cm      <= fall ? cm_nxt : '1;
            result_timeout <= ~fall;
          end
        end
        HOLDOFF: if (state_nxt == IDLE) last <= id;
        default: ;
      endcase
    end
  end

  assign trig         = (state == TRIG) ? (N_SENSORS'(1) << id) : '0;
  assign result_valid = (state == RESULT);
  assign result_id    = id;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler at a 2 MHz clock (2 clocks per microsecond).
module tb_sonar_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] sensor_mask = '0;
  logic [3:0] echo = '0;
  logic [3:0] trig;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic [1:0] result_id;
  logic [8:0] result_cm;
  logic       result_timeout;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;

  always #5 clk = ~clk;

  sonar_scheduler #(
    .CLK_FREQ(2_000_000), .N_SENSORS(4), .TRIG_US(10), .ECHO_WAIT_US(1000),
    .ECHO_MAX_US(2000), .HOLDOFF_US(200), .CM_W(9)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trig(trig), .result_valid(result_valid), .result_ready(result_ready),
    .result_id(result_id), .result_cm(result_cm), .result_timeout(result_timeout),
    .busy(busy)
  );

  always @(posedge clk) if (result_valid && result_ready) hs_count <= hs_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_checks++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic wait_trig(input string tag, input int max, output logic [3:0] seen);
    int c = 0;
    while (trig == 4'b0 && c < max) begin @(negedge clk); c++; end
    check(tag, 32'(trig != 4'b0), 32'd1);
    seen = trig;
  endtask

  task automatic wait_trig_low(input string tag, input int max);
    int c = 0;
    while (trig != 4'b0 && c < max) begin @(negedge clk); c++; end
    check(tag, 32'(trig), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int max, output int cyc);
    cyc = 0;
    while (!result_valid && cyc < max) begin @(negedge clk); cyc++; end
    check(tag, 32'(result_valid), 32'd1);
  endtask

  initial begin
    logic [3:0] seen;
    logic [1:0] id_snap;
    logic [8:0] cm_snap;
    int cyc, bad, hs0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_id", 32'(result_id), 32'd0);
    check("rst_cm", 32'(result_cm), 32'd0);
    check("rst_timeout", 32'(result_timeout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    sensor_mask = 4'b0101;
    enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    // Test 1: trigger width, 580 us echo -> 10 cm, rotation 0 -> 2 -> 0
    wait_trig("t1_trig_seen", 10, seen);
    check("t1_trig_first", 32'(seen), 32'h1);
    cyc = 0;
    while (trig != 4'b0 && cyc < 100) begin cyc++; @(negedge clk); end
    check("t1_trig_width", 32'(cyc), 32'd20);
    repeat (200) @(negedge clk);
    echo[0] = 1'b1;
    repeat (1160) @(negedge clk);
    echo[0] = 1'b0;
    wait_valid("t1_valid", 100, cyc);
    check("t1_id", 32'(result_id), 32'd0);
    check("t1_cm", 32'(result_cm), 32'd10);
    check("t1_timeout", 32'(result_timeout), 32'd0);
    wait_trig("t1_trig2_seen", 1000, seen);
    check("t1_trig2", 32'(seen), 32'h4);
    wait_trig_low("t1_trig2_low", 40);
    wait_valid("t1_s2_valid", 2100, cyc);
    check("t1_s2_id", 32'(result_id), 32'd2);
    check("t1_s2_timeout", 32'(result_timeout), 32'd1);
    wait_trig("t1_trig3_seen", 1000, seen);
    check("t1_trig3", 32'(seen), 32'h1);

    // Test 2: single sensor 1 with no echo
    sensor_mask = 4'b0010;
    wait_trig_low("t2_s0_low", 40);
    wait_valid("t2_s0_valid", 2100, cyc);
    check("t2_s0_id", 32'(result_id), 32'd0);
    wait_trig("t2_trig_seen", 1000, seen);
    check("t2_trig", 32'(seen), 32'h2);
    wait_trig_low("t2_low", 40);
    wait_valid("t2_valid", 2100, cyc);
    check_range("t2_wait_time", cyc, 1995, 2005);
    check("t2_id", 32'(result_id), 32'd1);
    check("t2_timeout", 32'(result_timeout), 32'd1);
    check("t2_cm", 32'(result_cm), 32'h1FF);
    wait_trig("t2_repeat_seen", 1000, seen);
    check("t2_repeat", 32'(seen), 32'h2);
    sensor_mask = 4'b0001;
    wait_trig_low("t2_repeat_low", 40);
    wait_valid("t2_repeat_valid", 2100, cyc);

    // Test 3 + 4: long echo timeout, then downstream stall
    wait_trig("t3_trig_seen", 1000, seen);
    check("t3_trig", 32'(seen), 32'h1);
    result_ready = 1'b0;
    wait_trig_low("t3_low", 40);
    repeat (100) @(negedge clk);
    echo[0] = 1'b1;
    wait_valid("t3_valid", 4100, cyc);
    check_range("t3_max_time", cyc, 3995, 4010);
    check("t3_id", 32'(result_id), 32'd0);
    check("t3_timeout", 32'(result_timeout), 32'd1);
    check("t3_cm", 32'(result_cm), 32'h1FF);
    id_snap = result_id;
    cm_snap = result_cm;
    hs0 = hs_count;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!(result_valid && result_id == id_snap && result_cm == cm_snap && trig == 4'b0)) bad++;
    end
    check("t4_stall_stable", 32'(bad), 32'd0);
    echo[0] = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", 32'(result_valid), 32'd0);
    check("t4_one_transfer", 32'(hs_count - hs0), 32'd1);

    // Test 5: async reset in the middle of a measurement
    wait_trig("t5_trig_seen", 1000, seen);
    sensor_mask = 4'b1111;
    wait_trig_low("t5_low", 40);
    repeat (100) @(negedge clk);
    echo[0] = 1'b1;
    repeat (300) @(negedge clk);
    check("t5_busy_measure", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_trig", 32'(trig), 32'd0);
    check("t5_rst_valid", 32'(result_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    echo[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_trig("t5_trig_after", 10, seen);
    check("t5_first_sensor", 32'(seen), 32'h1);

    // Test 6: enable drops mid-measurement, then empty mask
    wait_trig_low("t6_low", 40);
    repeat (200) @(negedge clk);
    echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    enable = 1'b0;
    repeat (132) @(negedge clk);
    echo[0] = 1'b0;
    wait_valid("t6_valid", 100, cyc);
    check("t6_id", 32'(result_id), 32'd0);
    check("t6_cm", 32'(result_cm), 32'd2);
    check("t6_timeout", 32'(result_timeout), 32'd0);
    cyc = 0;
    while (busy && cyc < 1000) begin @(negedge clk); cyc++; end
    check("t6_parked", 32'(busy), 32'd0);
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (trig != 4'b0 || busy) bad++;
    end
    check("t6_disabled_idle", 32'(bad), 32'd0);
    sensor_mask = 4'b0000;
    enable = 1'b1;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (trig != 4'b0 || busy) bad++;
    end
    check("t6_empty_mask_idle", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
